// File: rtl/output_read_sequencer_pkg.sv
// Shared output-slot definitions used by the write demux, the output bank and the read sequencer.
package output_pkg;

    localparam int unsigned NUM_SLOTS      = 16;
    localparam int unsigned SEL_W          = 4;
    localparam int unsigned SLOT_W         = 32;
    localparam int unsigned BYTES_PER_SLOT = SLOT_W / 8;
    localparam int unsigned BCNT_W         = (BYTES_PER_SLOT > 1) ? $clog2(BYTES_PER_SLOT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        SEND,
        DONE
    } seq_state_e;

endpackage

// File: rtl/output_read_sequencer_if.sv
// Bank read port plus outgoing byte stream seen by the read sequencer.
interface output_read_sequencer_if;
    import output_pkg::*;

    logic [SEL_W-1:0]  read_select;
    logic [SLOT_W-1:0] read_data;
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;

    modport master (
        output read_select,
        input  read_data,
        output byte_data,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  read_select,
        output read_data,
        input  byte_data,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/output_read_sequencer_word_byte_serializer.sv
// Turns one captured slot word into an MSB-first valid/ready byte stream.
module word_byte_serializer
    import output_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [SLOT_W-1:0] word_i,
    output logic [7:0]        byte_o,
    output logic              byte_valid_o,
    input  logic              byte_ready_i,
    output logic              last_accept_c_o
);

    logic [SLOT_W-1:0] shift_q;
    logic [BCNT_W-1:0] byte_cnt_q;
    logic              valid_q;
    logic              accept_c;

    assign accept_c        = valid_q & byte_ready_i;
    assign last_accept_c_o = accept_c && (byte_cnt_q == BCNT_W'(BYTES_PER_SLOT - 1));
    assign byte_o          = shift_q[SLOT_W-1 -: 8];
    assign byte_valid_o    = valid_q;

    // Valid drops only after the final byte of the word is taken, so nothing is dropped or repeated.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
            valid_q    <= 1'b0;
        end else if (load_i) begin
            shift_q    <= word_i;
            byte_cnt_q <= '0;
            valid_q    <= 1'b1;
        end else if (accept_c) begin
            shift_q <= shift_q << 8;
            if (last_accept_c_o) begin
                byte_cnt_q <= '0;
                valid_q    <= 1'b0;
            end else begin
                byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/output_read_sequencer.sv
// Walks every output slot through the bank read port and streams each word out as bytes.
module output_read_sequencer
    import output_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output_read_sequencer_if.master  bus
);

    seq_state_e       state_q, state_d;
    logic [SEL_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [SEL_W-1:0] read_select_q, read_select_d;
    logic             busy_q, done_q;
    logic             load_c;
    logic             last_accept_c;

    assign bus.read_select = read_select_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

    word_byte_serializer u_ser (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .load_i          (load_c),
        .word_i          (bus.read_data),
        .byte_o          (bus.byte_data),
        .byte_valid_o    (bus.byte_valid),
        .byte_ready_i    (bus.byte_ready),
        .last_accept_c_o (last_accept_c)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            slot_cnt_q    <= '0;
            read_select_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_cnt_q    <= slot_cnt_d;
            read_select_q <= read_select_d;
            busy_q        <= (state_d != IDLE);
            done_q        <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d       = state_q;
        slot_cnt_d    = slot_cnt_q;
        read_select_d = read_select_q;
        load_c        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = ADDR;
                    slot_cnt_d = '0;
                end
            end
            ADDR: state_d = WAIT;
            WAIT: begin
                load_c  = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (last_accept_c) begin
                    if (slot_cnt_q == SEL_W'(NUM_SLOTS - 1)) begin
                        state_d = DONE;
                    end else begin
                        slot_cnt_d = slot_cnt_q + SEL_W'(1);
                        state_d    = ADDR;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                slot_cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase

        // Select is presented from ADDR onward and held until the next slot's ADDR.
        if (state_d == ADDR) begin
            read_select_d = slot_cnt_d;
        end else if (state_d == IDLE) begin
            read_select_d = '0;
        end
    end

endmodule

// File: tb/tb_output_read_sequencer.sv
// Scoreboard bench for output_read_sequencer: bank model, random sink back-pressure, byte queue.
module tb_output_read_sequencer;
    import output_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done;
    logic rnd_mode = 1'b0;

    output_read_sequencer_if bus_if ();

    output_read_sequencer dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .busy_o  (busy),
        .done_o  (done),
        .bus     (bus_if.master)
    );

    always #5 clk = ~clk;

    logic [SLOT_W-1:0] bank [NUM_SLOTS];
    logic [7:0]        exp_q [$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_acc_cyc = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered bank: data for a select appears one cycle later.
    always @(posedge clk) bus_if.read_data <= bank[bus_if.read_select];

    // Sink: always ready, or ~30% duty when rnd_mode is set.
    always @(posedge clk) begin
        #1;
        bus_if.byte_ready = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expected byte per handshake, checks stall stability and done timing.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(bus_if.byte_valid), 32'd1);
                chk("hold_byte", 32'(bus_if.byte_data), 32'(prev_byte));
            end
            if (bus_if.byte_valid && bus_if.byte_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)", bus_if.byte_data, cyc);
                end else begin
                    chk("byte", 32'(bus_if.byte_data), 32'(exp_q.pop_front()));
                end
                last_acc_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                chk("done_timing", 32'(cyc), 32'(last_acc_cyc + 1));
            end
            prev_stall = bus_if.byte_valid && !bus_if.byte_ready;
            prev_byte  = bus_if.byte_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stream: every slot, bytes MSB first.
    task automatic push_dump();
        for (int k = 0; k < NUM_SLOTS; k++)
            for (int b = 0; b < BYTES_PER_SLOT; b++)
                exp_q.push_back(bank[k][SLOT_W-1-8*b -: 8]);
    endtask

    task automatic pattern_bank();
        for (int k = 0; k < NUM_SLOTS; k++) bank[k] = 32'hA0B0C000 + 32'(k);
    endtask

    task automatic wait_done(input int lim, input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < lim && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        pattern_bank();
        repeat (3) tick();
        @(negedge clk);
        chk("rst_sel", 32'(bus_if.read_select), 32'd0);
        chk("rst_byte", 32'(bus_if.byte_data), 32'd0);
        chk("rst_valid", 32'(bus_if.byte_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Full dump, ready high: latency, select trace, done and busy timing.
        push_dump();
        d0 = done_cnt;
        start = 1'b1;
        for (int c = 1; c <= 98; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            @(negedge clk);
            if (c <= 96) chk("sel_trace", 32'(bus_if.read_select), 32'((c - 1) / 6));
            if (c == 2) chk("valid_c2", 32'(bus_if.byte_valid), 32'd0);
            if (c == 3) chk("valid_c3", 32'(bus_if.byte_valid), 32'd1);
            if (c == 3) chk("first_byte", 32'(bus_if.byte_data), 32'hA0);
            if (c == 96) chk("done_c96", 32'(done), 32'd0);
            if (c == 97) chk("done_c97", 32'(done), 32'd1);
            if (c == 97) chk("busy_c97", 32'(busy), 32'd1);
            if (c == 98) chk("busy_c98", 32'(busy), 32'd0);
            if (c == 98) chk("done_c98", 32'(done), 32'd0);
        end
        chk("q_empty_1", 32'(exp_q.size()), 32'd0);
        chk("done_cnt_1", 32'(done_cnt - d0), 32'd1);
        tick();

        // Same data with random back-pressure.
        rnd_mode = 1'b1;
        push_dump();
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(3000, "timeout_rnd1");
        chk("q_empty_2", 32'(exp_q.size()), 32'd0);
        chk("done_cnt_2", 32'(done_cnt - d0), 32'd1);

        // Random bank contents with random back-pressure.
        for (int k = 0; k < NUM_SLOTS; k++) bank[k] = $urandom;
        push_dump();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(3000, "timeout_rnd2");
        chk("q_empty_3", 32'(exp_q.size()), 32'd0);
        pattern_bank();

        // start re-pulsed during slot 5 and during DONE is ignored.
        rnd_mode = 1'b0;
        repeat (2) tick();
        push_dump();
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (31) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (64) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_ignored", 32'(busy), 32'd0);
        repeat (5) tick();
        chk("q_empty_4", 32'(exp_q.size()), 32'd0);
        chk("done_cnt_4", 32'(done_cnt - d0), 32'd1);

        // Reset while byte 2 of slot 9 is on the stream.
        push_dump();
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (58) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_sel", 32'(bus_if.read_select), 32'd9);
        chk("pre_rst_byte", 32'(bus_if.byte_data), 32'hC0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_sel", 32'(bus_if.read_select), 32'd0);
        chk("mid_rst_byte", 32'(bus_if.byte_data), 32'd0);
        chk("mid_rst_valid", 32'(bus_if.byte_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done_cnt - d0), 32'd0);
        tick();
        push_dump();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("restart_valid", 32'(bus_if.byte_valid), 32'd1);
        chk("restart_byte", 32'(bus_if.byte_data), 32'hA0);
        wait_done(500, "timeout_restart");
        chk("q_empty_5", 32'(exp_q.size()), 32'd0);

        // start and rst together: reset wins.
        start = 1'b1;
        rst = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("sr_busy", 32'(busy), 32'd0);
            chk("sr_valid", 32'(bus_if.byte_valid), 32'd0);
            tick();
        end
        chk("q_empty_6", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
